// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the 9-bit CPU: sequential fetch, taken branches,
// jump-table subroutine calls with a hardware return stack, returns and halt.
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int SUB_BASE   = 100,
  parameter int SUB_STRIDE = 16,
  parameter int STK_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            br_req,
  input  logic            br_cond,
  input  logic [7:0]      br_target,
  input  logic            jsr_req,
  input  logic [3:0]      jsr_idx,
  input  logic            rts_req,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            fault,
  output logic [15:0]     retired
);

  localparam int AW   = $clog2(STK_DEPTH);
  localparam int SP_W = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic [PC_W-1:0] r_stack [STK_DEPTH];
  logic            r_running;
  logic            r_done;
  logic            r_fault;
  logic [15:0]     r_retired;

  logic            w_do_halt;
  logic            w_do_rts;
  logic            w_do_jsr;
  logic            w_do_br;
  logic            w_stk_empty;
  logic            w_stk_full;
  logic            w_stack_err;
  logic [AW-1:0]   w_push_idx;
  logic [AW-1:0]   w_pop_idx;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_jsr_target;
  logic [PC_W-1:0] w_br_target;
  logic [PC_W-1:0] w_next_pc;
  logic [15:0]     w_retired_next;

  // Requests are resolved halt > rts > jsr > br in case the decoder ever overlaps them.
  assign w_do_halt = halt_req;
  assign w_do_rts  = !halt_req && rts_req;
  assign w_do_jsr  = !halt_req && !rts_req && jsr_req;
  assign w_do_br   = !halt_req && !rts_req && !jsr_req && br_req && br_cond;

  assign w_stk_empty = (r_sp == '0);
  assign w_stk_full  = (r_sp == SP_W'(STK_DEPTH));
  assign w_stack_err = (w_do_rts && w_stk_empty) || (w_do_jsr && w_stk_full);

  // Low pointer bits wrap correctly for the pop index even when the stack is full.
  assign w_push_idx = r_sp[AW-1:0];
  assign w_pop_idx  = r_sp[AW-1:0] - AW'(1);

  assign w_pc_inc     = r_pc + PC_W'(1);
  assign w_jsr_target = PC_W'(SUB_BASE) + PC_W'(jsr_idx) * PC_W'(SUB_STRIDE);
  assign w_br_target  = PC_W'(br_target);

  assign w_retired_next = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;

  always_comb begin
    w_next_pc = w_pc_inc;
    if (w_do_halt) begin
      w_next_pc = r_pc;
    end else if (w_do_rts) begin
      w_next_pc = r_stack[w_pop_idx];
    end else if (w_do_jsr) begin
      w_next_pc = w_jsr_target;
    end else if (w_do_br) begin
      w_next_pc = w_br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_sp      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state   <= S_RUN;
            r_pc      <= PC_W'(START_ADDR);
            r_sp      <= '0;
            r_retired <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            // A stack error retires nothing and leaves pc on the offending instruction.
            if (w_stack_err) begin
              r_state   <= S_FAULT;
              r_running <= 1'b0;
              r_fault   <= 1'b1;
            end else begin
              r_pc      <= w_next_pc;
              r_retired <= w_retired_next;
              if (w_do_halt) begin
                r_state   <= S_HALT;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
              if (w_do_rts) begin
                r_sp <= r_sp - SP_W'(1);
              end
              if (w_do_jsr) begin
                r_stack[w_push_idx] <= w_pc_inc;
                r_sp                <= r_sp + SP_W'(1);
              end
            end
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc      = r_pc;
  assign running = r_running;
  assign done    = r_done;
  assign fault   = r_fault;
  assign retired = r_retired;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer for the 9-bit CPU. It owns the 10-bit `pc` that addresses `instr_memory` and advances it each cycle. It handles taken branches (register-held absolute target), subroutine calls through a fixed jump table with a hardware return stack, returns, and the `done` halt. It sits between the instruction decoder, which raises one-cycle request strobes, and the instruction memory. It also reports run, halt and fault status to the testbench and top level.

## Interface
- `PC_W`, 10, pc width; must match the `instr_memory` address width.
- `START_ADDR`, 0, pc loaded on `start`.
- `SUB_BASE`, 100, address of subroutine 0.
- `SUB_STRIDE`, 16, address spacing between subroutine entries; subroutine n is at `SUB_BASE + n*SUB_STRIDE`.
- `STK_DEPTH`, 4, return-stack entries (power of two, ≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse; begin execution at `START_ADDR`.
- `stall` in 1: hold `pc` and all state this cycle.
- `br_req` in 1: current instruction is `bnzr`.
- `br_cond` in 1: tested register is nonzero.
- `br_target` in 8: absolute target (z register).
- `jsr_req` in 1: current instruction is `jtsr`.
- `jsr_idx` in 4: subroutine number.
- `rts_req` in 1: current instruction is `rfsr`.
- `halt_req` in 1: current instruction is `done`.
- `pc` out PC_W: instruction address.
- `running` out 1: state is RUN.
- `done` out 1: state is HALT.
- `fault` out 1: state is FAULT.
- `retired` out 16: count of instructions retired, saturating.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - HALT.
  - FAULT.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --halt_req--> HALT.
  - RUN --stack error--> FAULT.
  - HALT --start--> RUN.
  - FAULT: left only by `reset`.
- `start` in IDLE or HALT: `pc <= START_ADDR`, stack pointer cleared, `retired` cleared.
- `start` in RUN or FAULT: ignored.
- Request inputs are sampled only in RUN with `stall=0`. In every other case they are ignored and `pc` holds.
- The decoder guarantees one request per cycle. If several are asserted anyway, priority is halt > rts > jsr > br.
- Next pc in RUN (no stall):
  - `halt_req`: `pc` holds at the `done` instruction; enter HALT.
  - `rts_req`, stack non-empty: pop; `pc <= popped value`.
  - `rts_req`, stack empty: enter FAULT; `pc` holds.
  - `jsr_req`, stack not full: push `pc+1` (mod 2^PC_W); `pc <= SUB_BASE + jsr_idx*SUB_STRIDE` (truncated to PC_W).
  - `jsr_req`, stack full: enter FAULT; `pc` holds; no push.
  - `br_req && br_cond`: `pc <= {2'b00, br_target}`.
  - `br_req && !br_cond`, or no request: `pc <= pc+1`. Wraps 1023 → 0 silently.
- Return stack:
  - LIFO, `STK_DEPTH` entries of PC_W bits.
  - Pointer counts 0..STK_DEPTH; full = STK_DEPTH, empty = 0.
  - Entries are not cleared on pop.
- `retired`:
  - Increments by 1 for every non-stalled RUN cycle, including the `halt_req` cycle.
  - Saturates at 16'hFFFF.
  - Does not increment on a faulting cycle.

## Timing
- `pc` is a register. `instr_memory` is combinational, so the instruction for `pc` is valid in the same cycle, and requests are decoded in that cycle.
- Redirect latency is 1 cycle: a branch, call or return taken at edge k puts the target on `pc` after edge k. There is no delay slot and no bubble.
- `start` sampled at edge k: `pc = START_ADDR` and `running = 1` after edge k.
- `done` and `fault` assert the cycle after the causing edge and are held until `start` (HALT) or `reset`.
- Reset values: `pc = 0`, state IDLE, stack pointer 0, `running = 0`, `done = 0`, `fault = 0`, `retired = 0`.
- Reset mid-RUN (including mid-subroutine) discards the stack and returns to IDLE at the next edge.
- `reset` overrides `start` and `stall` in the same cycle.
- `stall` in RUN freezes `pc`, stack, state and `retired`. Requests present during a stall are acted on only in the first non-stalled cycle in which they are still asserted.

## Test plan
- Reset, then `start`; no requests for 5 cycles → `pc` steps 0,1,2,3,4,5; `running = 1`; `retired = 5`.
- At pc 96: `br_req=1`, `br_cond=1`, `br_target=9` → next `pc = 9`. Repeat with `br_cond=0` → next `pc = 97`.
- At pc 45: `jsr_req`, `jsr_idx=0` → `pc = 100`. After 12 sequential cycles, `rts_req` at pc 112 → `pc = 46`. Stack is empty afterwards.
- Nested `jsr` 4 times (`STK_DEPTH=4`) → `pc` tracks each target; 5th `jsr` → `fault = 1`, `pc` held. Only `reset` clears the fault.
- `rts_req` with an empty stack → `fault = 1` next cycle. Separately, `halt_req` at pc 97 → `done = 1`, `pc = 97` held. A following `start` → `pc = 0`, `done = 0`, `retired = 0`.
- `stall` for 3 cycles while `br_req` is asserted → `pc` and `retired` frozen; the branch is taken on the first cycle after the stall. Force `pc = 1023` sequentially → next `pc = 0`.
